// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_sync_rw single-port RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_pkg;

  // Sweep sequencer states: CLEAR zero-fills the array, IDLE serves requests.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Deepest read pipe the design supports; READ_LAT is clamped into 1..READ_LAT_MAX.
  localparam int READ_LAT_MAX = 4;

  // Even-parity bit for one byte: the stored bit makes the total count of ones even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read response pipe: READ_LAT-deep valid/data shift register (plus parity-error flag with RAM_PARITY_EN).
// Latency: LAT cycles from in_valid to out_valid; stage 0 is the array sample register.
// Backpressure: none, advances every cycle; reset drops everything in flight.
module ram_rd_pipe #(
  parameter int DATA_W = 64,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
`ifdef RAM_PARITY_EN
  input  logic              in_perr,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
`ifdef RAM_PARITY_EN
  ,
  output logic              out_perr
`endif
);

  logic [LAT-1:0]             vld_q;
  logic [LAT-1:0][DATA_W-1:0] dat_q;
`ifdef RAM_PARITY_EN
  logic [LAT-1:0]             perr_q;
`endif

  // Shift valid/data one stage per cycle; data in stage 0 only loads on a real read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        dat_q[0] <= in_data;
      end
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

`ifdef RAM_PARITY_EN
  // Parity error travels with its read so it can only ever appear alongside out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_q <= '0;
    end else begin
      perr_q[0] <= in_valid & in_perr;
      for (int i = 1; i < LAT; i++) begin
        perr_q[i] <= perr_q[i-1];
      end
    end
  end

  assign out_perr = perr_q[LAT-1];
`endif

  assign out_valid = vld_q[LAT-1];
  assign out_data  = dat_q[LAT-1];

endmodule

// File: rtl/ram_sync_rw.sv
// Single-port synchronous RAM with valid/ready requests, byte enables and a zero-fill sweep; optional RAM_PARITY_EN.
// Latency: reads respond READ_LAT cycles after acceptance; writes take effect at the accepting edge.
// Backpressure: req_ready low while sweeping and in the cycle after clear_req; responses cannot be stalled.
module ram_sync_rw
  import ram_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 2048,
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  busy
`ifdef RAM_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int NB  = DATA_W / 8;
  // Out-of-range READ_LAT values are pulled back into the supported window.
  localparam int LAT = (READ_LAT < 1) ? 1 :
                       (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic                accept;
  logic                in_range;
  logic                wr_en;
  logic                rd_en;
  logic [DATA_W-1:0]   rd_data;

  // Storage is deliberately not reset; the sweep is the only thing that zeroes it.
  logic [DATA_W-1:0]   mem [DEPTH];
`ifdef RAM_PARITY_EN
  logic [NB-1:0]       par_mem [DEPTH];
  logic [NB-1:0]       rd_par;
  logic                rd_perr;
`endif

  // clear_req wins over an otherwise acceptable request because req_ready only drops a cycle later.
  assign accept   = req_valid & req_ready & ~clear_req;
  assign in_range = ({1'b0, req_addr} < DEPTH_X);
  assign wr_en    = accept & req_write & in_range;
  assign rd_en    = accept & ~req_write;

  // Sweep sequencer: CLEAR walks ptr 0..DEPTH-1 then hands over to IDLE; clear_req restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_CLEAR;
      ptr       <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
    end else if (clear_req) begin
      state     <= ST_CLEAR;
      ptr       <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (ptr == LAST) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ST_IDLE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= ST_CLEAR;
          ptr       <= '0;
          req_ready <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

  // Array write port: sweep zero-fill or byte-lane-masked request write (out-of-range writes dropped).
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (req_be[k]) begin
          mem[req_addr][8*k +: 8] <= req_wdata[8*k +: 8];
        end
      end
    end
  end

`ifdef RAM_PARITY_EN
  // Parity bits are written lane-by-lane alongside the data; the sweep stores parity 0 for zero data.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      par_mem[ptr] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (req_be[k]) begin
          par_mem[req_addr][k] <= byte_parity(req_wdata[8*k +: 8]);
        end
      end
    end
  end
`endif

  // Combinational array read; an out-of-range address reads as all-zero.
  always_comb begin
    rd_data = '0;
    if (in_range) begin
      rd_data = mem[req_addr];
    end
  end

`ifdef RAM_PARITY_EN
  // Compare recomputed lane parity against stored parity for the word being read.
  always_comb begin
    rd_par  = '0;
    rd_perr = 1'b0;
    if (in_range) begin
      rd_par = par_mem[req_addr];
    end
    for (int k = 0; k < NB; k++) begin
      if (byte_parity(rd_data[8*k +: 8]) != rd_par[k]) begin
        rd_perr = 1'b1;
      end
    end
  end
`endif

  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .LAT    (LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_en),
    .in_data   (rd_data),
`ifdef RAM_PARITY_EN
    .in_perr   (rd_perr),
`endif
    .out_valid (rsp_valid),
    .out_data  (rsp_rdata)
`ifdef RAM_PARITY_EN
    ,
    .out_perr  (parity_err)
`endif
  );

endmodule
